// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   DISP_DATA_W : width of the display driver's data word
//   NIBBLE_OVF  : nibble value shown on every digit when the input overflows
//   state_t     : converter FSM encoding (IDLE / SHIFT / DONE)
//   pow10()     : constant function, 10**n, used for the overflow threshold
package bin_to_bcd_seq_pkg;

  localparam int DISP_DATA_W = 32;
  localparam logic [3:0] NIBBLE_OVF = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_nibble_adj.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
//   din_i  : current BCD digit (0..9 in normal operation)
//   dout_o : corrected digit, din_i >= 5 ? din_i + 3 : din_i
module bcd_nibble_adj (
  input  logic [3:0] din_i,
  output logic [3:0] dout_o
);

  always_comb begin
    dout_o = din_i;
    if (din_i >= 4'd5) begin
      dout_o = din_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Feeds the 4-digit 7-segment driver; the output word only changes when a
// conversion completes, so the display never sees partial results.
//   clk      : system clock, all state on rising edge
//   reset    : synchronous active-high reset, discards any conversion in flight
//   in_valid : bin_in valid; accepted when in_valid && in_ready
//   in_ready : high only while idle
//   bin_in   : unsigned binary value to convert
//   bcd_data : digit k in bits [4k+3:4k]; all 0xF on overflow; unused upper bits 0
//   overflow : last accepted value was >= 10**DIGITS
//   done     : one-cycle pulse, coincident with the bcd_data/overflow update
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int DIGITS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        bin_in,
  output logic [DISP_DATA_W-1:0] bcd_data,
  output logic                   overflow,
  output logic                   done
);

  localparam int WORK_W = 4 * DIGITS;
  localparam int CNT_W  = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_W);
  localparam logic [63:0] OVF_LIMIT = pow10(DIGITS);

  state_t                   state_q, state_d;
  logic [IN_W-1:0]          shift_q, shift_d;
  logic [WORK_W-1:0]        work_q, work_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     ovf_pend_q, ovf_pend_d;
  logic [DISP_DATA_W-1:0]   bcd_data_q, bcd_data_d;
  logic                     overflow_q, overflow_d;
  logic                     done_q, done_d;

  // Work register after the per-digit add-3 correction. Each nibble is
  // corrected independently; no carry crosses a digit boundary.
  logic [WORK_W-1:0]        work_adj;
  logic [WORK_W+IN_W-1:0]   cat_shift;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    bcd_nibble_adj u_adj (
      .din_i  (work_q[4*gi +: 4]),
      .dout_o (work_adj[4*gi +: 4])
    );
  end

  // {work, shift} moves left as one register: the shift MSB enters the work LSB.
  assign cat_shift = {work_adj, shift_q} << 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_data_q <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_data_q <= bcd_data_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_data_d = bcd_data_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d    = bin_in;
          work_d     = '0;
          cnt_d      = CNT_LOAD;
          // Decided up front from the raw input: an out-of-range value is
          // shown as all-F rather than as a truncated decimal.
          ovf_pend_d = (64'(bin_in) >= OVF_LIMIT);
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        work_d  = cat_shift[WORK_W+IN_W-1:IN_W];
        shift_d = cat_shift[IN_W-1:0];
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        bcd_data_d = '0;
        bcd_data_d[WORK_W-1:0] = ovf_pend_q ? {DIGITS{NIBBLE_OVF}} : work_q;
        overflow_d = ovf_pend_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready = (state_q == IDLE);
  assign bcd_data = bcd_data_q;
  assign overflow = overflow_q;
  assign done     = done_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bin_in;
  logic [31:0] bcd_data;
  logic        overflow;
  logic        done;

  int checks   = 0;
  int failures = 0;

  bin_to_bcd_seq #(.IN_W(16), .DIGITS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bin_in   (bin_in),
    .bcd_data (bcd_data),
    .overflow (overflow),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent decimal model: repeated division, all-F above 9999.
  function automatic logic [31:0] ref_bcd(input int v);
    logic [31:0] r;
    int x;
    if (v >= 10000) return 32'h0000_FFFF;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r = r | (32'(x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  // Called #1 after an edge with the DUT idle. Accepts v on the next edge E,
  // toggles in_valid randomly while busy, and checks done appears at E+17.
  task automatic do_conv(input logic [15:0] v, input logic [31:0] exp_bcd, input logic exp_ovf);
    int n;
    logic [31:0] prev;
    logic busy_bad;
    check_eq("rdy_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    bin_in   = v;
    @(posedge clk); #1;
    prev     = bcd_data;
    busy_bad = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      if (in_ready !== 1'b0 || bcd_data !== prev || overflow === 1'bx) busy_bad = 1'b1;
      in_valid = 1'($urandom_range(0, 1));
      bin_in   = 16'($urandom_range(0, 65535));
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check_eq("busy_hold", 32'(busy_bad), 32'd0);
    check_eq("latency", 32'(n), 32'd17);
    check_eq("bcd_data", bcd_data, exp_bcd);
    check_eq("overflow", 32'(overflow), 32'(exp_ovf));
    $display("conv bin=%0d bcd=%h ovf=%0d cycles=%0d", v, bcd_data, overflow, n);
    @(posedge clk); #1;
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("bcd_hold_after", bcd_data, exp_bcd);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    int v;
    logic seen_done;
    reset    = 1'b1;
    in_valid = 1'b0;
    bin_in   = '0;

    // 1. Reset for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rst_bcd", bcd_data, 32'h0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // 2/3. Directed values and boundaries
    do_conv(16'd1234,  32'h0000_1234, 1'b0);
    do_conv(16'd0,     32'h0000_0000, 1'b0);
    do_conv(16'd9999,  32'h0000_9999, 1'b0);
    do_conv(16'd10000, 32'h0000_FFFF, 1'b1);
    do_conv(16'd65535, 32'h0000_FFFF, 1'b1);
    do_conv(16'd805,   32'h0000_0805, 1'b0);

    // 4. in_valid held high: 42 then 7
    in_valid = 1'b1;
    bin_in   = 16'd42;
    @(posedge clk); #1;
    bin_in = 16'd7;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("b2b_first_lat", 32'(n), 32'd17);
    check_eq("b2b_first_bcd", bcd_data, 32'h0000_0042);
    $display("conv bin=42 bcd=%h cycles=%0d", bcd_data, n);
    @(posedge clk); #1;
    n++;
    check_eq("b2b_busy_ready", 32'(in_ready), 32'd0);
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check_eq("b2b_second_lat", 32'(n), 32'd35);
    check_eq("b2b_second_bcd", bcd_data, 32'h0000_0007);
    $display("conv bin=7 bcd=%h cycles=%0d", bcd_data, n);
    @(posedge clk); #1;

    // 5. Reset mid-conversion of 5678
    in_valid = 1'b1;
    bin_in   = 16'd5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("midrst_bcd", bcd_data, 32'h0);
    check_eq("midrst_ready", 32'(in_ready), 32'd1);
    seen_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    check_eq("midrst_no_done", 32'(seen_done), 32'd0);
    check_eq("midrst_bcd_hold", bcd_data, 32'h0);
    $display("conv bin=5678 aborted by reset bcd=%h", bcd_data);

    // 6. Random values against the decimal model
    for (int k = 0; k < 10; k++) begin
      v = int'($urandom_range(0, 65535));
      do_conv(16'(v), ref_bcd(v), (v >= 10000) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
